// File: rtl/behavioral_fsm_serial_adder_pkg.sv
// Shared types for the bit-serial adder/subtractor family.
// The FSM state is the running carry, encoded as a single bit.
package behavioral_fsm_serial_adder_pkg;

  typedef enum logic {
    C0 = 1'b0,
    C1 = 1'b1
  } carry_state_t;

  // Majority of the two operand bits and the incoming carry.
  function automatic carry_state_t nextCarry(input logic a, input logic b, input carry_state_t c);
    logic cv;
    cv = (c == C1);
    return ((a & b) | (a & cv) | (b & cv)) ? C1 : C0;
  endfunction

endpackage

// File: rtl/behavioral_fsm_serial_adder_if.sv
// Serial operand/result bundle: the two operand bits, the advance strobe and the sum bit.
interface behavioral_fsm_serial_adder_if;

  logic a;
  logic b;
  logic enable;
  logic s;

  modport master (output a, output b, output enable, input s);
  modport slave  (input a, input b, input enable, output s);

endinterface

// File: rtl/behavioral_fsm_serial_adder.sv
// Two-state Mealy serial adder: the state is the carry, the sum bit is combinational.
// Word framing (reset at word start, enable to advance) is supplied by the surrounding datapath.
module behavioral_fsm_serial_adder
  import behavioral_fsm_serial_adder_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  behavioral_fsm_serial_adder_if.slave bus
);

  carry_state_t r_state;
  carry_state_t w_next_state;
  logic         w_sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= C0;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operands are only looked at while enabled, so unknown a/b cannot reach the carry when paused.
  always_comb begin
    w_next_state = r_state;
    w_sum        = 1'b0;
    if (reset && bus.enable) begin
      w_sum        = bus.a ^ bus.b ^ (r_state == C1);
      w_next_state = nextCarry(bus.a, bus.b, r_state);
    end
  end

  assign bus.s = w_sum;

endmodule

// File: tb/tb_behavioral_fsm_serial_adder.sv
// Self-checking bench for the serial adder: directed scenarios plus random words
// compared against an integer-arithmetic reference.
module tb_behavioral_fsm_serial_adder;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   mCarry;

  behavioral_fsm_serial_adder_if bus ();

  behavioral_fsm_serial_adder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 ns before the rising edge.
  task automatic applyStimulus(input logic rst, input logic ia, input logic ib, input logic ien);
    @(negedge clk);
    reset      = rst;
    bus.a      = ia;
    bus.b      = ib;
    bus.enable = ien;
    #4;
  endtask

  // Reference: carry as an integer, sum bit = (a + b + carry) mod 2, carry' = (a + b + carry) / 2.
  function automatic logic modelStep();
    int total;
    if (reset !== 1'b1) begin
      mCarry = 0;
      return 1'b0;
    end
    if (bus.enable !== 1'b1) return 1'b0;
    total  = int'(bus.a) + int'(bus.b) + mCarry;
    mCarry = total / 2;
    return logic'(total % 2);
  endfunction

  task automatic checkValue(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed s=%b expected s=%b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic exp;
    exp = modelStep();
    checkValue(tag, bus.s, exp);
  endtask

  task automatic checkWord(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed word=%0d expected word=%0d", tag, obs, exp);
    end
  endtask

  // a=1, b=0 leaves the carry unchanged and makes s the inverse of the carry.
  task automatic probeCarry(input string tag, input int expCarry);
    logic dummy;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    dummy = modelStep();
    checkValue(tag, bus.s, (expCarry == 0));
  endtask

  task automatic runWord(input string tag, input int opA, input int opB, input int n,
                         input bit pauses, output int res);
    res = 0;
    for (int i = 0; i < n; i++) begin
      if (pauses && $urandom_range(0, 3) == 0) begin
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        checkOutput({tag, "_pause"});
      end
      applyStimulus(1'b1, 1'((opA >> i) & 1), 1'((opB >> i) & 1), 1'b1);
      checkOutput(tag);
      res = res | (int'(bus.s) << i);
    end
  endtask

  initial begin
    int res;
    int opA;
    int opB;
    int n;
    int cin;
    int mask;

    tests      = 0;
    fails      = 0;
    mCarry     = 0;
    reset      = 1'b0;
    bus.a      = 1'b0;
    bus.b      = 1'b0;
    bus.enable = 1'b0;

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkValue("reset_s", bus.s, 1'b0);
    void'(modelStep());
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("release_s");

    runWord("add_bit", 104, 94, 8, 1'b0, res);
    checkWord("add_104_94", res, 198);
    probeCarry("add_carry_end", 0);

    runWord("neg_bit", 15, 1, 4, 1'b0, res);
    checkWord("neg_m1_p1", res, 0);
    probeCarry("neg_carry_stuck", 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("neg_reset_s");
    probeCarry("neg_after_reset", 0);

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("pause_setup");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'(i & 1), 1'((i + 1) & 1), 1'b0);
      checkValue("pause_s", bus.s, 1'b0);
      void'(modelStep());
    end
    applyStimulus(1'b1, 1'bx, 1'bx, 1'b0);
    checkOutput("pause_x_s");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkValue("pause_resume", bus.s, 1'b1);
    void'(modelStep());

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("async_setup");
    @(negedge clk);
    bus.a      = 1'b1;
    bus.b      = 1'b0;
    bus.enable = 1'b1;
    #1 reset = 1'b0;
    #1 checkOutput("async_asserted");
    #1 reset = 1'b1;
    #1 checkValue("async_cleared", bus.s, 1'b1);
    void'(modelStep());
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkValue("async_next_lsb", bus.s, 1'b0);
    void'(modelStep());

    for (int c = 0; c < 2; c++) begin
      for (int ab = 0; ab < 4; ab++) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("fa_reset");
        if (c == 1) begin
          applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
          checkOutput("fa_set_c1");
        end
        applyStimulus(1'b1, 1'(ab >> 1), 1'(ab & 1), 1'b1);
        checkValue("fa_sum", bus.s, 1'(((ab >> 1) + (ab & 1) + c) % 2));
        void'(modelStep());
        probeCarry("fa_carry", ((ab >> 1) + (ab & 1) + c) / 2);
      end
    end

    for (int w = 0; w < 24; w++) begin
      if ($urandom_range(0, 1) == 1) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rnd_reset");
      end
      n    = $urandom_range(1, 16);
      mask = (1 << n) - 1;
      opA  = int'($urandom_range(0, 65535)) & mask;
      opB  = int'($urandom_range(0, 65535)) & mask;
      cin  = mCarry;
      runWord("rnd_bit", opA, opB, n, 1'b1, res);
      checkWord("rnd_word", res, (opA + opB + cin) & mask);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
